instr_mem_pipe: RTL and testbench
=================================

# instr_mem_pipe

Registered, parametrised successor to the combinational instruction memory. Provides a word-aligned fetch port and a byte/halfword/word data-load port, both with one-cycle registered read latency, plus a byte-strobed write port for program loading and self-modifying stores. Misaligned loads crossing a word boundary are handled by a two-beat state machine with a ready/valid handshake so the pipeline can stall. Sits between the fetch/memory stages and the word-organised program store.

## Interface
- `DATA_WIDTH`, 32, word width (fixed at 32; other values unsupported)
- `ADDR_WIDTH`, 32, byte-address width
- `MEM_SIZE`, 512, depth in words
- `NOP_WORD`, 32'h00000013, fetch value for out-of-range/reset
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `f_req` in 1: fetch request
- `f_addr` in ADDR_WIDTH: fetch byte address; bits [1:0] ignored
- `f_valid` out 1: fetch data valid
- `f_rdata` out 32: fetched instruction
- `d_req` in 1: load request
- `d_addr` in ADDR_WIDTH: load byte address
- `d_load_type` in 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- `d_ready` out 1: load request accepted this cycle when `d_req & d_ready`
- `d_valid` out 1: load result valid (one-cycle pulse)
- `d_rdata` out 32: extended load result
- `d_err` out 1: qualifies `d_valid`; invalid type or out-of-range byte
- `w_en` in 1: write enable
- `w_addr` in ADDR_WIDTH: write byte address; bits [1:0] ignored
- `w_data` in 32: write data
- `w_strb` in 4: byte-lane enables, bit n = bits [8n+7:8n]

## Operation
- Storage: `MEM_SIZE` x 32 array, little-endian; not cleared by reset.
- Fetch: `f_req` sampled at edge; next cycle `f_valid`=1, `f_rdata`=word at `f_addr[..2]`, or `NOP_WORD` if index >= `MEM_SIZE`. `f_valid`=0 when no request. Fetch never stalls.
- Data FSM states: IDLE, SECOND. `d_ready`=1 only in IDLE.
- IDLE, accepted non-crossing load (any byte; halfword offset 0–2; word offset 0): read word, extract, extend; `d_valid` next cycle; stay IDLE.
- IDLE, accepted crossing load (halfword offset 3; word offset 1–3): latch low bytes of word N, type, offset; go SECOND.
- SECOND: read word N+1, merge (bytes from N at top offsets, then N+1 low bytes), extend; `d_valid` at end of cycle; return IDLE.
- Out-of-range: any byte from word index >= `MEM_SIZE` reads 0 and sets `d_err`. No wrap-around at top of memory.
- Invalid `d_load_type`: single-beat, `d_rdata`=0, `d_err`=1.
- Write: commits at edge for lanes with `w_strb` set; index >= `MEM_SIZE` ignored silently.
- Read/write collision same cycle, same word: read returns old data (read-first). A write in the first beat of a crossing load is visible to the SECOND-beat read of word N+1.

## Timing
- Reset values: `f_valid`=0, `f_rdata`=`NOP_WORD`, `d_valid`=0, `d_rdata`=0, `d_err`=0, FSM=IDLE (`d_ready`=1 after release).
- Fetch latency 1 cycle, throughput 1/cycle.
- Load latency 1 cycle non-crossing (1/cycle back-to-back), 2 cycles crossing (`d_ready`=0 during SECOND).
- `d_rdata`/`d_err` hold last value when `d_valid`=0.
- `rst_n` asserted mid-SECOND: abort immediately to IDLE, no `d_valid` emitted.

## Configuration
- `INSTR_MEM_MISALIGN_EN` defined: crossing loads use the two-beat SECOND path as above.
- Not defined: SECOND state removed, `d_ready` tied 1; any crossing load completes in one cycle with `d_rdata`=0, `d_err`=1.

## Test plan
- Fetch: preload word 0=0x12345678, `f_req` at 0x0 -> next cycle `f_valid`=1, `f_rdata`=0x12345678; `f_addr`=0x800 (index 512) -> 0x00000013.
- Byte/half extension: word 1=0x80FF7F01; LB 0x5 -> 0xFFFFFF80... (byte 0x7F at 0x5 -> 0x0000007F), LB 0x7 -> 0xFFFFFF80, LBU 0x7 -> 0x00000080, LH 0x6 -> 0xFFFF80FF.
- Crossing word: word0=0x44332211, word1=0x88776655; LW 0x1 -> `d_ready` low 1 cycle, 2 cycles later 0x55443322; LH 0x3 -> 0x00005544 via LHU, `d_err`=0.
- Boundary: LW 0x7FD (crosses past MEM_SIZE) -> `d_rdata`=0x00000000 upper bytes zero, `d_err`=1; invalid type 3'b011 -> 0, `d_err`=1.
- Write/collision: write 0xAABBCCDD strb 4'b0101 to 0x4 while LW 0x4 same cycle -> load returns old word; next LW -> lanes 0,2 updated.
- Reset mid-SECOND: start LW 0x2, assert `rst_n` low in SECOND -> no `d_valid`, `d_ready`=1 after release; macro undefined: LW 0x2 -> one cycle, `d_err`=1.

Source files
------------

// File: rtl/instr_mem_pipe.sv
// instr_mem_pipe: word-organised program store with a registered fetch port,
// a registered byte/halfword/word load port and a byte-strobed write port.
//
// Optional feature macro: INSTR_MEM_MISALIGN_EN
//   defined     : loads crossing a word boundary take a second beat (SECOND
//                 state), d_ready drops for that beat.
//   not defined : crossing loads complete in one cycle with d_rdata=0, d_err=1;
//                 d_ready is tied high.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   f_req/f_addr      : fetch request and byte address (bits [1:0] ignored)
//   f_valid/f_rdata   : fetch result, one cycle after the request
//   d_req/d_addr      : load request and byte address
//   d_load_type       : 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   d_ready           : load accepted when d_req & d_ready
//   d_valid/d_rdata   : load result pulse and extended data (data holds)
//   d_err             : invalid load type or out-of-range byte
//   w_en/w_addr       : write enable and byte address (bits [1:0] ignored)
//   w_data/w_strb     : write data and byte-lane enables
module instr_mem_pipe #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           MEM_SIZE   = 512,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h0000_0013
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    f_req,
   input  logic [ADDR_WIDTH-1:0]   f_addr,
   output logic                    f_valid,
   output logic [DATA_WIDTH-1:0]   f_rdata,
   input  logic                    d_req,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [2:0]              d_load_type,
   output logic                    d_ready,
   output logic                    d_valid,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    d_err,
   input  logic                    w_en,
   input  logic [ADDR_WIDTH-1:0]   w_addr,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic [DATA_WIDTH/8-1:0] w_strb
);

   localparam int unsigned IW     = ADDR_WIDTH - 2;
   localparam int unsigned IWP1   = IW + 1;
   localparam int unsigned IDX_W  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
   localparam int unsigned NLANES = DATA_WIDTH / 8;
   localparam logic [IW:0] MEM_LIMIT = IWP1'(MEM_SIZE);

   // Word-aligned byte-address bits that carry no information
   logic w_unused;
   assign w_unused = ^{f_addr[1:0], w_addr[1:0]};

   // Shift the (hi,lo) word pair down to the addressed byte, then extend
   function automatic logic [DATA_WIDTH-1:0] load_extend(
      input logic [2*DATA_WIDTH-1:0] pair,
      input logic [1:0]              off,
      input logic [2:0]              lt
   );
      logic [DATA_WIDTH-1:0] sh;
      logic [DATA_WIDTH-1:0] res;
      sh  = DATA_WIDTH'(pair >> {off, 3'b000});
      res = '0;
      case (lt)
         3'b000:  res = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
         3'b001:  res = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
         3'b010:  res = sh;
         3'b100:  res = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
         3'b101:  res = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
         default: res = '0;
      endcase
      return res;
   endfunction

   // Storage, not cleared by reset
   logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

   // ---------------------------------------------------------------- write
   logic [IW-1:0] w_w_idx;
   logic          w_w_inr;
   assign w_w_idx = w_addr[ADDR_WIDTH-1:2];
   assign w_w_inr = {1'b0, w_w_idx} < MEM_LIMIT;

   // Reads are combinational from the array and registered, so a same-edge
   // write is seen only by later reads (read-first)
   always_ff @(posedge clk) begin
      if (w_en && w_w_inr) begin
         for (int b = 0; b < NLANES; b++) begin
            if (w_strb[b]) begin
               r_mem[IDX_W'(w_w_idx)][8*b +: 8] <= w_data[8*b +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------- fetch
   logic [IW-1:0]         w_f_idx;
   logic                  w_f_inr;
   logic                  r_f_valid;
   logic [DATA_WIDTH-1:0] r_f_rdata;
   assign w_f_idx = f_addr[ADDR_WIDTH-1:2];
   assign w_f_inr = {1'b0, w_f_idx} < MEM_LIMIT;

   // Fetch register; data holds when no request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_f_valid <= 1'b0;
         r_f_rdata <= NOP_WORD;
      end else begin
         r_f_valid <= f_req;
         if (f_req) begin
            r_f_rdata <= w_f_inr ? r_mem[IDX_W'(w_f_idx)] : NOP_WORD;
         end
      end
   end

   assign f_valid = r_f_valid;
   assign f_rdata = r_f_rdata;

   // ----------------------------------------------------------- load decode
   logic [IW-1:0]         w_d_idx;
   logic [1:0]            w_d_off;
   logic                  w_d_inr;
   logic [DATA_WIDTH-1:0] w_d_word;
   logic                  w_lt_ok;
   logic                  w_d_cross;
   logic [DATA_WIDTH-1:0] w_sb_rdata;
   logic                  w_sb_err;

   assign w_d_idx  = d_addr[ADDR_WIDTH-1:2];
   assign w_d_off  = d_addr[1:0];
   assign w_d_inr  = {1'b0, w_d_idx} < MEM_LIMIT;
   assign w_d_word = w_d_inr ? r_mem[IDX_W'(w_d_idx)] : '0;
   assign w_lt_ok  = d_load_type inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

   // Halfword at offset 3 or word at non-zero offset spans two words
   assign w_d_cross = w_lt_ok &&
                      (((d_load_type[1:0] == 2'b01) && (w_d_off == 2'b11)) ||
                       ((d_load_type[1:0] == 2'b10) && (w_d_off != 2'b00)));

   // Single-beat result: invalid type, crossing or out-of-range yield 0/err
   always_comb begin
      w_sb_rdata = '0;
      w_sb_err   = 1'b1;
      if (w_lt_ok && !w_d_cross && w_d_inr) begin
         w_sb_rdata = load_extend({{DATA_WIDTH{1'b0}}, w_d_word}, w_d_off, d_load_type);
         w_sb_err   = 1'b0;
      end
   end

   // Next values of the registered load outputs
   logic                  w_dv_nxt;
   logic [DATA_WIDTH-1:0] w_drdata_nxt;
   logic                  w_derr_nxt;

   logic                  r_d_valid;
   logic [DATA_WIDTH-1:0] r_d_rdata;
   logic                  r_d_err;

`ifdef INSTR_MEM_MISALIGN_EN
   typedef enum logic {
      S_IDLE   = 1'b0,
      S_SECOND = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_lat_en;
   logic [DATA_WIDTH-1:0] r_lo_word;
   logic                  r_lo_err;
   logic [IW-1:0]         r_lo_idx;
   logic [1:0]            r_lo_off;
   logic [2:0]            r_lo_lt;
   logic [IW:0]           w_n_idx;
   logic                  w_n_inr;
   logic [DATA_WIDTH-1:0] w_n_word;

   // Second word is N+1 with one extra bit so the top of memory never wraps
   assign w_n_idx  = {1'b0, r_lo_idx} + IWP1'(1);
   assign w_n_inr  = w_n_idx < MEM_LIMIT;
   assign w_n_word = w_n_inr ? r_mem[IDX_W'(w_n_idx)] : '0;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // First-beat capture of word N and the request attributes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lo_word <= '0;
         r_lo_err  <= 1'b0;
         r_lo_idx  <= '0;
         r_lo_off  <= 2'b00;
         r_lo_lt   <= 3'b000;
      end else if (w_lat_en) begin
         r_lo_word <= w_d_word;
         r_lo_err  <= !w_d_inr;
         r_lo_idx  <= w_d_idx;
         r_lo_off  <= w_d_off;
         r_lo_lt   <= d_load_type;
      end
   end

   // Next-state and load-output logic
   always_comb begin
      w_state_nxt  = r_state;
      w_lat_en     = 1'b0;
      w_dv_nxt     = 1'b0;
      w_drdata_nxt = r_d_rdata;
      w_derr_nxt   = r_d_err;
      case (r_state)
         S_IDLE: begin
            if (d_req) begin
               if (w_d_cross) begin
                  w_lat_en    = 1'b1;
                  w_state_nxt = S_SECOND;
               end else begin
                  w_dv_nxt     = 1'b1;
                  w_drdata_nxt = w_sb_rdata;
                  w_derr_nxt   = w_sb_err;
               end
            end
         end
         S_SECOND: begin
            w_dv_nxt     = 1'b1;
            w_drdata_nxt = load_extend({w_n_word, r_lo_word}, r_lo_off, r_lo_lt);
            w_derr_nxt   = r_lo_err | !w_n_inr;
            w_state_nxt  = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign d_ready = (r_state == S_IDLE);
`else
   // Every load completes in a single beat
   always_comb begin
      w_dv_nxt     = 1'b0;
      w_drdata_nxt = r_d_rdata;
      w_derr_nxt   = r_d_err;
      if (d_req) begin
         w_dv_nxt     = 1'b1;
         w_drdata_nxt = w_sb_rdata;
         w_derr_nxt   = w_sb_err;
      end
   end

   assign d_ready = 1'b1;
`endif

   // Load output registers; data and error hold between results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d_valid <= 1'b0;
         r_d_rdata <= '0;
         r_d_err   <= 1'b0;
      end else begin
         r_d_valid <= w_dv_nxt;
         r_d_rdata <= w_drdata_nxt;
         r_d_err   <= w_derr_nxt;
      end
   end

   assign d_valid = r_d_valid;
   assign d_rdata = r_d_rdata;
   assign d_err   = r_d_err;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Self-checking bench for instr_mem_pipe. Inputs change on the falling edge,
// outputs are sampled on the following falling edge.
module tb_instr_mem_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_valid;
   logic [31:0] f_rdata;
   logic        d_req;
   logic [31:0] d_addr;
   logic [2:0]  d_load_type;
   logic        d_ready;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        w_en;
   logic [31:0] w_addr;
   logic [31:0] w_data;
   logic [3:0]  w_strb;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   instr_mem_pipe dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .f_req       (f_req),
      .f_addr      (f_addr),
      .f_valid     (f_valid),
      .f_rdata     (f_rdata),
      .d_req       (d_req),
      .d_addr      (d_addr),
      .d_load_type (d_load_type),
      .d_ready     (d_ready),
      .d_valid     (d_valid),
      .d_rdata     (d_rdata),
      .d_err       (d_err),
      .w_en        (w_en),
      .w_addr      (w_addr),
      .w_data      (w_data),
      .w_strb      (w_strb)
   );

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  lt;
      logic [31:0] exp_data;
      logic        exp_err;
      string       nm;
   } ld_vec_t;

   ld_vec_t vec [18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
      end
   endtask

   // Called at a falling edge; returns at the next falling edge
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      w_en = 1'b1; w_addr = a; w_data = d; w_strb = s;
      @(negedge clk);
      w_en = 1'b0; w_strb = 4'b0000;
   endtask

   // Boundary-crossing load; expectations depend on the build
   task automatic ld_cross(input logic [31:0] a, input logic [2:0] lt,
                           input logic [31:0] exp_d, input logic exp_e, input string nm);
      d_req = 1'b1; d_addr = a; d_load_type = lt;
      @(negedge clk);
      d_req = 1'b0;
`ifdef INSTR_MEM_MISALIGN_EN
      chk({nm, " ready_second"}, 32'(d_ready), 32'd0);
      chk({nm, " valid_first"},  32'(d_valid), 32'd0);
      @(negedge clk);
      chk({nm, " valid"}, 32'(d_valid), 32'd1);
      chk({nm, " data"},  d_rdata, exp_d);
      chk({nm, " err"},   32'(d_err), 32'(exp_e));
`else
      chk({nm, " valid"}, 32'(d_valid), 32'd1);
      chk({nm, " data"},  d_rdata, 32'd0);
      chk({nm, " err"},   32'(d_err), 32'd1);
`endif
      chk({nm, " ready_after"}, 32'(d_ready), 32'd1);
   endtask

   initial begin
      vec[0]  = '{32'h005, 3'b000, 32'h0000007F, 1'b0, "LB 0x5"};
      vec[1]  = '{32'h007, 3'b000, 32'hFFFFFF80, 1'b0, "LB 0x7"};
      vec[2]  = '{32'h007, 3'b100, 32'h00000080, 1'b0, "LBU 0x7"};
      vec[3]  = '{32'h006, 3'b001, 32'hFFFF80FF, 1'b0, "LH 0x6"};
      vec[4]  = '{32'h006, 3'b101, 32'h000080FF, 1'b0, "LHU 0x6"};
      vec[5]  = '{32'h004, 3'b001, 32'h00007F01, 1'b0, "LH 0x4"};
      vec[6]  = '{32'h004, 3'b010, 32'h80FF7F01, 1'b0, "LW 0x4"};
      vec[7]  = '{32'h006, 3'b000, 32'hFFFFFFFF, 1'b0, "LB 0x6"};
      vec[8]  = '{32'h002, 3'b101, 32'h00001234, 1'b0, "LHU 0x2"};
      vec[9]  = '{32'h000, 3'b010, 32'h12345678, 1'b0, "LW 0x0"};
      vec[10] = '{32'h7FC, 3'b000, 32'hFFFFFFA5, 1'b0, "LB 0x7FC"};
      vec[11] = '{32'h800, 3'b010, 32'h00000000, 1'b1, "LW 0x800"};
      vec[12] = '{32'h803, 3'b100, 32'h00000000, 1'b1, "LBU 0x803"};
      vec[13] = '{32'h000, 3'b011, 32'h00000000, 1'b1, "type 011"};
      vec[14] = '{32'h004, 3'b110, 32'h00000000, 1'b1, "type 110"};
      vec[15] = '{32'h7FD, 3'b111, 32'h00000000, 1'b1, "type 111 cross"};
      vec[16] = '{32'h001, 3'b001, 32'h00003456, 1'b0, "LH 0x1"};
      vec[17] = '{32'h010, 3'b010, 32'h00FF00FF, 1'b0, "LW 0x10 strb"};

      rst_n = 1'b0;
      f_req = 1'b0; f_addr = '0;
      d_req = 1'b0; d_addr = '0; d_load_type = 3'b000;
      w_en = 1'b0; w_addr = '0; w_data = '0; w_strb = 4'b0000;
      repeat (3) @(negedge clk);

      chk("rst f_valid", 32'(f_valid), 32'd0);
      chk("rst f_rdata", f_rdata, 32'h00000013);
      chk("rst d_valid", 32'(d_valid), 32'd0);
      chk("rst d_rdata", d_rdata, 32'd0);
      chk("rst d_err",   32'(d_err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst d_ready", 32'(d_ready), 32'd1);

      // Preload
      wr(32'h000, 32'h12345678, 4'hF);
      wr(32'h004, 32'h80FF7F01, 4'hF);
      wr(32'h008, 32'h44332211, 4'hF);
      wr(32'h00C, 32'h88776655, 4'hF);
      wr(32'h010, 32'hFFFFFFFF, 4'hF);
      wr(32'h010, 32'h00000000, 4'b1010);
      wr(32'h7FC, 32'h000000A5, 4'hF);
      wr(32'h800, 32'hDEADBEEF, 4'hF);

      // Fetch
      f_req = 1'b1; f_addr = 32'h000;
      @(negedge clk);
      chk("fetch 0x0 valid", 32'(f_valid), 32'd1);
      chk("fetch 0x0 data", f_rdata, 32'h12345678);
      f_addr = 32'h007;
      @(negedge clk);
      chk("fetch 0x7 data", f_rdata, 32'h80FF7F01);
      f_addr = 32'h800;
      @(negedge clk);
      chk("fetch 0x800 data", f_rdata, 32'h00000013);
      f_addr = 32'h7FC;
      @(negedge clk);
      chk("fetch 0x7FC data", f_rdata, 32'h000000A5);
      f_req = 1'b0;
      @(negedge clk);
      chk("fetch idle valid", 32'(f_valid), 32'd0);

      // Back-to-back single-beat loads
      for (int i = 0; i < 18; i++) begin
         chk({vec[i].nm, " ready"}, 32'(d_ready), 32'd1);
         d_req = 1'b1; d_addr = vec[i].addr; d_load_type = vec[i].lt;
         @(negedge clk);
         chk({vec[i].nm, " valid"}, 32'(d_valid), 32'd1);
         chk({vec[i].nm, " data"},  d_rdata, vec[i].exp_data);
         chk({vec[i].nm, " err"},   32'(d_err), 32'(vec[i].exp_err));
      end
      d_req = 1'b0;
      @(negedge clk);
      chk("hold valid", 32'(d_valid), 32'd0);
      chk("hold data",  d_rdata, 32'h00FF00FF);

      // Read-first collision, then updated lanes
      d_req = 1'b1; d_addr = 32'h004; d_load_type = 3'b010;
      w_en = 1'b1; w_addr = 32'h004; w_data = 32'hAABBCCDD; w_strb = 4'b0101;
      @(negedge clk);
      w_en = 1'b0; w_strb = 4'b0000;
      chk("collide old data", d_rdata, 32'h80FF7F01);
      @(negedge clk);
      d_req = 1'b0;
      chk("collide new data", d_rdata, 32'h80BB7FDD);

      // Boundary-crossing loads
      ld_cross(32'h009, 3'b010, 32'h55443322, 1'b0, "LW 0x9");
      ld_cross(32'h00B, 3'b101, 32'h00005544, 1'b0, "LHU 0xB");
      ld_cross(32'h00B, 3'b010, 32'h77665544, 1'b0, "LW 0xB");
      ld_cross(32'h007, 3'b001, 32'h00001180, 1'b0, "LH 0x7");
      ld_cross(32'h00F, 3'b001, 32'hFFFFFF88, 1'b0, "LH 0xF");
      ld_cross(32'h7FD, 3'b010, 32'h00000000, 1'b1, "LW 0x7FD");

      // Write during the first beat is seen by the second-beat read
      w_en = 1'b1; w_addr = 32'h00C; w_data = 32'h000000EE; w_strb = 4'b0001;
      ld_cross(32'h009, 3'b010, 32'hEE443322, 1'b0, "LW 0x9 wr");
      w_en = 1'b0; w_strb = 4'b0000;

      // Reset while a crossing load is in its second beat
      d_req = 1'b1; d_addr = 32'h002; d_load_type = 3'b010;
      @(negedge clk);
      d_req = 1'b0;
`ifdef INSTR_MEM_MISALIGN_EN
      chk("rst2 ready_second", 32'(d_ready), 32'd0);
`else
      chk("rst2 single valid", 32'(d_valid), 32'd1);
      chk("rst2 single err",   32'(d_err), 32'd1);
      chk("rst2 single data",  d_rdata, 32'd0);
`endif
      rst_n = 1'b0;
      #1;
      chk("rst2 valid in rst", 32'(d_valid), 32'd0);
      chk("rst2 ready in rst", 32'(d_ready), 32'd1);
      @(negedge clk);
      chk("rst2 valid held", 32'(d_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst2 valid after", 32'(d_valid), 32'd0);
      chk("rst2 ready after", 32'(d_ready), 32'd1);
      chk("rst2 err after",   32'(d_err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
